// File: rtl/issue_queue_int_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | issue_queue_int_pkg                                                  |
// | Shared types and constants for the integer/ld-st/mul issue queues.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package issue_queue_int_pkg;

  localparam int IQ_TAG_W  = 5;
  localparam int IQ_DATA_W = 32;

  // Integer ALU opcodes
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SLL = 4'h5;
  localparam logic [3:0] OP_SRL = 4'h6;
  localparam logic [3:0] OP_SRA = 4'h7;
  localparam logic [3:0] OP_SLT = 4'h8;

  typedef struct packed {
    logic                 valid;
    logic [IQ_DATA_W-1:0] rs_data;
    logic                 rs_valid;
    logic [IQ_TAG_W-1:0]  rs_tag;
    logic [IQ_DATA_W-1:0] rt_data;
    logic                 rt_valid;
    logic [IQ_TAG_W-1:0]  rt_tag;
    logic [IQ_TAG_W-1:0]  rd_tag;
    logic [3:0]           opcode;
    logic [4:0]           shfamt;
  } iq_entry_t;

  // A pending operand picks up a CDB broadcast only while it is still waiting.
  function automatic logic tag_hit(input logic                op_valid,
                                   input logic [IQ_TAG_W-1:0] op_tag,
                                   input logic                cdb_valid,
                                   input logic [IQ_TAG_W-1:0] cdb_tag);
    return !op_valid && cdb_valid && (op_tag == cdb_tag);
  endfunction

endpackage
`default_nettype wire

// File: rtl/issue_queue_int_select.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iq_select                                                            |
// | One-hot picker over a ready vector. Lowest index wins by default;    |
// | with ISSUEQ_AGE_ORDER_EN the smallest age wins (ties -> lowest idx). |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module iq_select #(
  parameter int N = 4
`ifdef ISSUEQ_AGE_ORDER_EN
  , parameter int AGE_W = 2
`endif
) (
  input  logic [N-1:0]            ready,
`ifdef ISSUEQ_AGE_ORDER_EN
  input  logic [N-1:0][AGE_W-1:0] ages,
`endif
  output logic [N-1:0]            grant,
  output logic                    grant_valid
);

`ifdef ISSUEQ_AGE_ORDER_EN
  logic [AGE_W-1:0] best_age;

  // Oldest ready entry wins; strict compare keeps the lower index on a tie.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    best_age    = '0;
    for (int i = 0; i < N; i++) begin
      if (ready[i] && (!grant_valid || (ages[i] < best_age))) begin
        grant       = '0;
        grant[i]    = 1'b1;
        grant_valid = 1'b1;
        best_age    = ages[i];
      end
    end
  end
`else
  // Lowest-index ready entry wins.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (ready[i] && !grant_valid) begin
        grant[i]    = 1'b1;
        grant_valid = 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/issue_queue_int.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | issue_queue_int                                                      |
// | Integer issue queue: accepts dispatched instructions, wakes pending  |
// | operands from the CDB, issues one ready entry per cycle into a       |
// | registered slot for the integer ALU.                                 |
// | Optional: ISSUEQ_AGE_ORDER_EN selects oldest-first instead of        |
// | lowest-index-first.                                                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module issue_queue_int
  import issue_queue_int_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = IQ_TAG_W,
  parameter int DATA_W = IQ_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dispatch_en,
  input  logic [DATA_W-1:0] dispatch_rs_data,
  input  logic              dispatch_rs_data_valid,
  input  logic [TAG_W-1:0]  dispatch_rs_tag,
  input  logic [DATA_W-1:0] dispatch_rt_data,
  input  logic              dispatch_rt_data_valid,
  input  logic [TAG_W-1:0]  dispatch_rt_tag,
  input  logic [TAG_W-1:0]  dispatch_rd_tag,
  input  logic [3:0]        dispatch_opcode,
  input  logic [4:0]        dispatch_shfamt,
  output logic              issueque_full,
  input  logic              Cdb_valid,
  input  logic [TAG_W-1:0]  Cdb_rd_tag,
  input  logic [DATA_W-1:0] Cdb_data,
  input  logic              flush,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [DATA_W-1:0] issue_rs_data,
  output logic [DATA_W-1:0] issue_rt_data,
  output logic [TAG_W-1:0]  issue_rd_tag,
  output logic [3:0]        issue_opcode,
  output logic [4:0]        issue_shfamt
);

  localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef ISSUEQ_AGE_ORDER_EN
  localparam int AGE_W = $clog2(DEPTH);
`endif

  iq_entry_t         entries [DEPTH];
  iq_entry_t         new_entry;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic [DEPTH-1:0]  ready_vec;
  logic [DEPTH-1:0]  free_onehot;
  logic              free_found;
  logic [DEPTH-1:0]  grant;
  logic              grant_valid;
  logic              accept;
  logic              load;
  logic              rs_bypass;
  logic              rt_bypass;
  logic [DATA_W-1:0] sel_rs_data;
  logic [DATA_W-1:0] sel_rt_data;
  logic [TAG_W-1:0]  sel_rd_tag;
  logic [3:0]        sel_opcode;
  logic [4:0]        sel_shfamt;

  // A full queue blocks dispatch even if an entry frees on this same edge.
  assign accept = dispatch_en && !issueque_full;
  assign load   = grant_valid && (!issue_valid || issue_ready);

  assign rs_bypass = tag_hit(dispatch_rs_data_valid, dispatch_rs_tag, Cdb_valid, Cdb_rd_tag);
  assign rt_bypass = tag_hit(dispatch_rt_data_valid, dispatch_rt_tag, Cdb_valid, Cdb_rd_tag);

  // Entry image for a dispatch, with operands already broadcast this cycle folded in.
  always_comb begin
    new_entry          = '0;
    new_entry.valid    = 1'b1;
    new_entry.rs_data  = rs_bypass ? Cdb_data : dispatch_rs_data;
    new_entry.rs_valid = dispatch_rs_data_valid || rs_bypass;
    new_entry.rs_tag   = dispatch_rs_tag;
    new_entry.rt_data  = rt_bypass ? Cdb_data : dispatch_rt_data;
    new_entry.rt_valid = dispatch_rt_data_valid || rt_bypass;
    new_entry.rt_tag   = dispatch_rt_tag;
    new_entry.rd_tag   = dispatch_rd_tag;
    new_entry.opcode   = dispatch_opcode;
    new_entry.shfamt   = dispatch_shfamt;
  end

  // Ready vector and lowest free slot from the current entry state.
  always_comb begin
    ready_vec   = '0;
    free_onehot = '0;
    free_found  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ready_vec[i] = entries[i].valid && entries[i].rs_valid && entries[i].rt_valid;
      if (!entries[i].valid && !free_found) begin
        free_onehot[i] = 1'b1;
        free_found     = 1'b1;
      end
    end
  end

`ifdef ISSUEQ_AGE_ORDER_EN
  logic [DEPTH-1:0][AGE_W-1:0] age;
  logic [AGE_W-1:0]            sel_age;
  logic [AGE_W-1:0]            new_age;

  // A write that coincides with a free lands after the survivors shift down,
  // so it takes count-1 to keep ages dense and unique.
  assign new_age = AGE_W'(count - CNT_W'(load));

  // Age of the entry being granted.
  always_comb begin
    sel_age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) sel_age = age[i];
    end
  end

  // Age bookkeeping: stamp on write, younger entries close the gap on a free.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      age <= '0;
    end else if (flush) begin
      age <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (accept && free_onehot[i]) begin
          age[i] <= new_age;
        end else if (load && entries[i].valid && !grant[i] && (age[i] > sel_age)) begin
          age[i] <= age[i] - 1'b1;
        end
      end
    end
  end
`endif

  iq_select #(
    .N(DEPTH)
`ifdef ISSUEQ_AGE_ORDER_EN
    , .AGE_W(AGE_W)
`endif
  ) u_select (
    .ready      (ready_vec),
`ifdef ISSUEQ_AGE_ORDER_EN
    .ages       (age),
`endif
    .grant      (grant),
    .grant_valid(grant_valid)
  );

  // Fields of the granted entry, muxed by the one-hot grant.
  always_comb begin
    sel_rs_data = '0;
    sel_rt_data = '0;
    sel_rd_tag  = '0;
    sel_opcode  = '0;
    sel_shfamt  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        sel_rs_data = entries[i].rs_data;
        sel_rt_data = entries[i].rt_data;
        sel_rd_tag  = entries[i].rd_tag;
        sel_opcode  = entries[i].opcode;
        sel_shfamt  = entries[i].shfamt;
      end
    end
  end

  // Entry storage: free on issue, write on dispatch, otherwise snoop the CDB.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) entries[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (load && grant[i]) begin
          entries[i].valid <= 1'b0;
        end else if (accept && free_onehot[i]) begin
          entries[i] <= new_entry;
        end else if (entries[i].valid) begin
          if (tag_hit(entries[i].rs_valid, entries[i].rs_tag, Cdb_valid, Cdb_rd_tag)) begin
            entries[i].rs_data  <= Cdb_data;
            entries[i].rs_valid <= 1'b1;
          end
          if (tag_hit(entries[i].rt_valid, entries[i].rt_tag, Cdb_valid, Cdb_rd_tag)) begin
            entries[i].rt_data  <= Cdb_data;
            entries[i].rt_valid <= 1'b1;
          end
        end
      end
    end
  end

  assign count_next = count + CNT_W'(accept) - CNT_W'(load);

  // Occupancy count and registered full flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count         <= '0;
      issueque_full <= 1'b0;
    end else if (flush) begin
      count         <= '0;
      issueque_full <= 1'b0;
    end else begin
      count         <= count_next;
      issueque_full <= (count_next == CNT_W'(DEPTH));
    end
  end

  // Issue slot: load when empty or being consumed, drain when consumed with nothing ready.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      issue_valid   <= 1'b0;
      issue_rs_data <= '0;
      issue_rt_data <= '0;
      issue_rd_tag  <= '0;
      issue_opcode  <= '0;
      issue_shfamt  <= '0;
    end else if (flush) begin
      issue_valid   <= 1'b0;
      issue_rs_data <= '0;
      issue_rt_data <= '0;
      issue_rd_tag  <= '0;
      issue_opcode  <= '0;
      issue_shfamt  <= '0;
    end else if (load) begin
      issue_valid   <= 1'b1;
      issue_rs_data <= sel_rs_data;
      issue_rt_data <= sel_rt_data;
      issue_rd_tag  <= sel_rd_tag;
      issue_opcode  <= sel_opcode;
      issue_shfamt  <= sel_shfamt;
    end else if (issue_ready) begin
      issue_valid   <= 1'b0;
    end
  end

  a_count_bound: assert property (@(posedge clock) disable iff (reset)
    count <= CNT_W'(DEPTH));
  a_no_underflow: assert property (@(posedge clock) disable iff (reset)
    !(load && (count == '0)));
  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(accept && !load && (count == CNT_W'(DEPTH))));

endmodule
`default_nettype wire

// File: tb/tb_issue_queue_int.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_issue_queue_int                                                   |
// | Directed bench for issue_queue_int with an arrival-ordered model.    |
// | Honours ISSUEQ_AGE_ORDER_EN for the selection policy.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_issue_queue_int;
  import issue_queue_int_pkg::*;

  localparam int DEPTH = 4;

  logic        clock, reset;
  logic        dispatch_en;
  logic [31:0] dispatch_rs_data, dispatch_rt_data;
  logic        dispatch_rs_data_valid, dispatch_rt_data_valid;
  logic [4:0]  dispatch_rs_tag, dispatch_rt_tag, dispatch_rd_tag;
  logic [3:0]  dispatch_opcode;
  logic [4:0]  dispatch_shfamt;
  logic        issueque_full;
  logic        Cdb_valid;
  logic [4:0]  Cdb_rd_tag;
  logic [31:0] Cdb_data;
  logic        flush;
  logic        issue_valid, issue_ready;
  logic [31:0] issue_rs_data, issue_rt_data;
  logic [4:0]  issue_rd_tag;
  logic [3:0]  issue_opcode;
  logic [4:0]  issue_shfamt;

  issue_queue_int #(.DEPTH(DEPTH), .TAG_W(5), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .dispatch_en(dispatch_en),
    .dispatch_rs_data(dispatch_rs_data), .dispatch_rs_data_valid(dispatch_rs_data_valid),
    .dispatch_rs_tag(dispatch_rs_tag),
    .dispatch_rt_data(dispatch_rt_data), .dispatch_rt_data_valid(dispatch_rt_data_valid),
    .dispatch_rt_tag(dispatch_rt_tag),
    .dispatch_rd_tag(dispatch_rd_tag), .dispatch_opcode(dispatch_opcode),
    .dispatch_shfamt(dispatch_shfamt),
    .issueque_full(issueque_full),
    .Cdb_valid(Cdb_valid), .Cdb_rd_tag(Cdb_rd_tag), .Cdb_data(Cdb_data),
    .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs_data(issue_rs_data), .issue_rt_data(issue_rt_data),
    .issue_rd_tag(issue_rd_tag), .issue_opcode(issue_opcode), .issue_shfamt(issue_shfamt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // Slots hold waiting instructions; 'stamp' is the arrival number, so the
  // oldest instruction is simply the one with the smallest stamp.
  typedef struct {
    bit          v;
    logic [31:0] rs;  bit rsv; logic [4:0] rst;
    logic [31:0] rt;  bit rtv; logic [4:0] rtt;
    logic [4:0]  rd;  logic [3:0] op; logic [4:0] sh;
    int          stamp;
  } m_ent_t;

  m_ent_t      mq [DEPTH];
  bit          m_iv, m_full;
  logic [31:0] m_rs, m_rt;
  logic [4:0]  m_rd, m_sh;
  logic [3:0]  m_op;
  int          m_next_stamp;
  int          pick, freei, cnt;
  bit          acc, ld;

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) mq[i].v = 1'b0;
    m_iv = 0; m_full = 0;
    m_rs = '0; m_rt = '0; m_rd = '0; m_op = '0; m_sh = '0;
  endfunction

  initial begin
    model_clear();
    m_next_stamp = 0;
  end

  always @(posedge clock or posedge reset) begin
    if (reset || flush) begin
      model_clear();
    end else begin
      pick = -1;
      for (int i = 0; i < DEPTH; i++) begin
        if (mq[i].v && mq[i].rsv && mq[i].rtv) begin
          if (pick < 0) pick = i;
`ifdef ISSUEQ_AGE_ORDER_EN
          else if (mq[i].stamp < mq[pick].stamp) pick = i;
`endif
        end
      end
      freei = -1;
      for (int i = 0; i < DEPTH; i++) if (!mq[i].v && freei < 0) freei = i;
      acc = dispatch_en && !m_full;
      ld  = (pick >= 0) && (!m_iv || issue_ready);
      if (ld) begin
        m_iv = 1; m_rs = mq[pick].rs; m_rt = mq[pick].rt;
        m_rd = mq[pick].rd; m_op = mq[pick].op; m_sh = mq[pick].sh;
        mq[pick].v = 0;
      end else if (issue_ready) begin
        m_iv = 0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (mq[i].v && Cdb_valid) begin
          if (!mq[i].rsv && mq[i].rst == Cdb_rd_tag) begin mq[i].rs = Cdb_data; mq[i].rsv = 1; end
          if (!mq[i].rtv && mq[i].rtt == Cdb_rd_tag) begin mq[i].rt = Cdb_data; mq[i].rtv = 1; end
        end
      end
      if (acc && freei >= 0) begin
        mq[freei].v   = 1;
        mq[freei].rsv = dispatch_rs_data_valid || (Cdb_valid && Cdb_rd_tag == dispatch_rs_tag);
        mq[freei].rs  = (!dispatch_rs_data_valid && Cdb_valid && Cdb_rd_tag == dispatch_rs_tag)
                        ? Cdb_data : dispatch_rs_data;
        mq[freei].rst = dispatch_rs_tag;
        mq[freei].rtv = dispatch_rt_data_valid || (Cdb_valid && Cdb_rd_tag == dispatch_rt_tag);
        mq[freei].rt  = (!dispatch_rt_data_valid && Cdb_valid && Cdb_rd_tag == dispatch_rt_tag)
                        ? Cdb_data : dispatch_rt_data;
        mq[freei].rtt = dispatch_rt_tag;
        mq[freei].rd  = dispatch_rd_tag;
        mq[freei].op  = dispatch_opcode;
        mq[freei].sh  = dispatch_shfamt;
        mq[freei].stamp = m_next_stamp;
        m_next_stamp++;
      end
      cnt = 0;
      for (int i = 0; i < DEPTH; i++) if (mq[i].v) cnt++;
      m_full = (cnt == DEPTH);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (!reset) begin
      chk("cyc_issue_valid", {31'b0, issue_valid}, {31'b0, m_iv});
      chk("cyc_full", {31'b0, issueque_full}, {31'b0, m_full});
      if (m_iv) begin
        chk("cyc_rs_data", issue_rs_data, m_rs);
        chk("cyc_rt_data", issue_rt_data, m_rt);
        chk("cyc_rd_tag", {27'b0, issue_rd_tag}, {27'b0, m_rd});
        chk("cyc_opcode", {28'b0, issue_opcode}, {28'b0, m_op});
        chk("cyc_shfamt", {27'b0, issue_shfamt}, {27'b0, m_sh});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge clock);
    dispatch_en = 0; Cdb_valid = 0; flush = 0;
  endtask

  task automatic disp(input logic [31:0] rs, input bit rsv, input logic [4:0] rst,
                      input logic [31:0] rt, input bit rtv, input logic [4:0] rtt,
                      input logic [4:0] rd, input logic [3:0] op);
    dispatch_en = 1;
    dispatch_rs_data = rs; dispatch_rs_data_valid = rsv; dispatch_rs_tag = rst;
    dispatch_rt_data = rt; dispatch_rt_data_valid = rtv; dispatch_rt_tag = rtt;
    dispatch_rd_tag = rd; dispatch_opcode = op; dispatch_shfamt = rd + 5'd1;
  endtask

  task automatic cdb(input logic [4:0] t, input logic [31:0] d);
    Cdb_valid = 1; Cdb_rd_tag = t; Cdb_data = d;
  endtask

  initial begin
    reset = 1; flush = 0; issue_ready = 0; dispatch_en = 0; Cdb_valid = 0;
    Cdb_rd_tag = '0; Cdb_data = '0;
    dispatch_rs_data = '0; dispatch_rs_data_valid = 0; dispatch_rs_tag = '0;
    dispatch_rt_data = '0; dispatch_rt_data_valid = 0; dispatch_rt_tag = '0;
    dispatch_rd_tag = '0; dispatch_opcode = '0; dispatch_shfamt = '0;
    @(negedge clock); @(negedge clock);
    reset = 0;
    chk("rst_issue_valid", {31'b0, issue_valid}, 32'd0);
    chk("rst_full", {31'b0, issueque_full}, 32'd0);
    chk("rst_rs_data", issue_rs_data, 32'd0);
    cyc();

    // Ready-at-dispatch instruction issues one edge after it is written.
    issue_ready = 1;
    disp(32'd5, 1, 5'd0, 32'd7, 1, 5'd0, 5'd3, OP_ADD); cyc();
    chk("add_not_yet", {31'b0, issue_valid}, 32'd0);
    cyc();
    chk("add_valid", {31'b0, issue_valid}, 32'd1);
    chk("add_rs", issue_rs_data, 32'd5);
    chk("add_rt", issue_rt_data, 32'd7);
    chk("add_rd", {27'b0, issue_rd_tag}, 32'd3);
    cyc();
    chk("add_drain", {31'b0, issue_valid}, 32'd0);

    // Wakeup from the CDB; a non-matching tag does nothing.
    disp(32'd0, 0, 5'd9, 32'd2, 1, 5'd0, 5'd4, OP_SUB); cyc();
    cdb(5'd8, 32'h55); cyc();
    chk("wake_wrong_tag", {31'b0, issue_valid}, 32'd0);
    cdb(5'd9, 32'h1234); cyc();
    chk("wake_edge", {31'b0, issue_valid}, 32'd0);
    cyc();
    chk("wake_valid", {31'b0, issue_valid}, 32'd1);
    chk("wake_rs", issue_rs_data, 32'h1234);
    cyc();

    // Dispatch-time bypass of a same-cycle broadcast.
    disp(32'h11, 1, 5'd0, 32'd0, 0, 5'd4, 5'd5, OP_AND); cdb(5'd4, 32'hAA); cyc();
    cyc();
    chk("byp_valid", {31'b0, issue_valid}, 32'd1);
    chk("byp_rt", issue_rt_data, 32'hAA);
    chk("byp_rs", issue_rs_data, 32'h11);
    cyc();

    // Fill to full, reject the fifth, then free one entry.
    issue_ready = 0;
    for (int i = 0; i < 4; i++) begin
      disp(32'd0, 0, 5'(10 + i), 32'd1, 1, 5'd0, 5'(16 + i), OP_OR); cyc();
      chk("fill_full", {31'b0, issueque_full}, (i == 3) ? 32'd1 : 32'd0);
    end
    disp(32'h77, 1, 5'd0, 32'h88, 1, 5'd0, 5'd20, OP_XOR); cyc();
    chk("fifth_ignored_full", {31'b0, issueque_full}, 32'd1);
    chk("fifth_ignored_iv", {31'b0, issue_valid}, 32'd0);
    issue_ready = 1;
    disp(32'h77, 1, 5'd0, 32'h88, 1, 5'd0, 5'd20, OP_XOR); cdb(5'd10, 32'h100); cyc();
    chk("wake_still_full", {31'b0, issueque_full}, 32'd1);
    disp(32'h77, 1, 5'd0, 32'h88, 1, 5'd0, 5'd20, OP_XOR); cyc();
    chk("load_iv", {31'b0, issue_valid}, 32'd1);
    chk("load_rs", issue_rs_data, 32'h100);
    chk("load_rd", {27'b0, issue_rd_tag}, 32'd16);
    chk("load_unfull", {31'b0, issueque_full}, 32'd0);
    disp(32'h77, 1, 5'd0, 32'h88, 1, 5'd0, 5'd20, OP_XOR); cyc();
    chk("retry_full", {31'b0, issueque_full}, 32'd1);
    cyc();
    chk("retry_rd", {27'b0, issue_rd_tag}, 32'd20);
    chk("retry_rt", issue_rt_data, 32'h88);
    cdb(5'd11, 32'h111); cyc();
    cdb(5'd12, 32'h122); cyc();
    cdb(5'd13, 32'h133); cyc();
    cyc(); cyc(); cyc();

    // Flush wins over a same-cycle dispatch.
    issue_ready = 0; flush = 1; cyc();
    disp(32'd1, 1, 5'd0, 32'd2, 1, 5'd0, 5'd7, OP_XOR); cyc();
    cyc();
    for (int i = 0; i < 3; i++) begin
      disp(32'd0, 0, 5'(24 + i), 32'd0, 1, 5'd0, 5'(8 + i), OP_ADD); cyc();
    end
    chk("pre_flush_iv", {31'b0, issue_valid}, 32'd1);
    chk("pre_flush_rd", {27'b0, issue_rd_tag}, 32'd7);
    flush = 1; disp(32'd3, 1, 5'd0, 32'd4, 1, 5'd0, 5'd9, OP_ADD); cyc();
    chk("flush_iv", {31'b0, issue_valid}, 32'd0);
    chk("flush_full", {31'b0, issueque_full}, 32'd0);
    chk("flush_rs", issue_rs_data, 32'd0);
    chk("flush_rd", {27'b0, issue_rd_tag}, 32'd0);
    issue_ready = 1;
    cdb(5'd24, 32'h24); cyc();
    cyc();
    chk("flush_dropped", {31'b0, issue_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      disp(32'd0, 0, 5'(27 + i), 32'd0, 1, 5'd0, 5'd1, OP_ADD); cyc();
      chk("post_flush_count", {31'b0, issueque_full}, (i == 3) ? 32'd1 : 32'd0);
    end
    flush = 1; cyc();

    // Out-of-order fill: entry 2 older than entry 0, both ready.
    issue_ready = 0;
    disp(32'd0, 0, 5'd20, 32'd1, 1, 5'd0, 5'd10, OP_ADD); cyc();
    disp(32'd0, 0, 5'd21, 32'd1, 1, 5'd0, 5'd11, OP_ADD); cdb(5'd20, 32'hA0); cyc();
    disp(32'd0, 0, 5'd22, 32'd1, 1, 5'd0, 5'd12, OP_ADD); cyc();
    chk("age_slot_a", {27'b0, issue_rd_tag}, 32'd10);
    disp(32'd0, 0, 5'd23, 32'd1, 1, 5'd0, 5'd14, OP_ADD); cyc();
    cdb(5'd22, 32'hC0); cyc();
    cdb(5'd23, 32'hE0); cyc();
    chk("age_slot_hold", {27'b0, issue_rd_tag}, 32'd10);
    issue_ready = 1; cyc();
`ifdef ISSUEQ_AGE_ORDER_EN
    chk("age_first", {27'b0, issue_rd_tag}, 32'd12);
`else
    chk("age_first", {27'b0, issue_rd_tag}, 32'd14);
`endif
    cyc();
`ifdef ISSUEQ_AGE_ORDER_EN
    chk("age_second", {27'b0, issue_rd_tag}, 32'd14);
`else
    chk("age_second", {27'b0, issue_rd_tag}, 32'd12);
`endif
    cyc();
    chk("age_drain", {31'b0, issue_valid}, 32'd0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
